fb_fizzle_writer: RTL and testbench



---
 rtl/fb_fizzle_writer.sv | 85 ++++++++
 tb/tb_fb_fizzle_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_fizzle_writer.sv
// fb_fizzle_writer: fills every framebuffer pixel with one colour in LFSR (fizzlefade) order
module fb_fizzle_writer #(
    parameter int                  FB_PIXELS = 19200,
    parameter int                  FB_ADDRW  = 15,
    parameter int                  CIDXW     = 4,
    parameter int                  LFSR_LEN  = 15,
    parameter logic [LFSR_LEN-1:0] TAPS      = 15'b110000000000000,
    parameter logic [LFSR_LEN-1:0] SEED      = 1,
    parameter int                  RATEW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [CIDXW-1:0]    colr,
    input  logic [RATEW-1:0]    rate,
    output logic                busy,
    output logic                done,
    output logic                fb_we,
    output logic [FB_ADDRW-1:0] fb_addr,
    output logic [CIDXW-1:0]    fb_colr
);
    localparam logic [LFSR_LEN-1:0] PIX = LFSR_LEN'(FB_PIXELS);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [LFSR_LEN-1:0] lfsr, lfsr_nx, lfsr_adv, cand;
    logic [RATEW-1:0] cnt, cnt_nx, rate_q, rate_nx;
    logic [CIDXW-1:0] colr_q, colr_nx, fb_colr_nx;
    logic [FB_ADDRW-1:0] fb_addr_nx;
    logic busy_nx, done_nx, fb_we_nx;
    logic go, act, skip, fire, adv, wr;
    assign lfsr_adv = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    assign cand = lfsr - LFSR_LEN'(1);
    assign skip = cand >= PIX;
    assign fire = cnt == rate_q;
    assign go = state == IDLE && start && !stop;
    assign act = state == RUN && !stop;
    assign adv = act && (skip || fire);
    assign wr = act && !skip && fire;
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state: a run ends once the LFSR wraps back to the seed
    always_comb begin
        state_nx = go ? RUN : (adv && lfsr_adv == SEED) ? FIN : act ? RUN : IDLE;
    end
    // next values of the datapath and of the registered outputs
    always_comb begin
        lfsr_nx = go ? SEED : adv ? lfsr_adv : lfsr;
        cnt_nx = (go || adv) ? '0 : act ? cnt + RATEW'(1) : cnt;
        rate_nx = go ? rate : rate_q;
        colr_nx = go ? colr : colr_q;
        busy_nx = state_nx != IDLE;
        done_nx = state == FIN;
        fb_we_nx = wr;
        fb_addr_nx = wr ? FB_ADDRW'(cand) : fb_addr;
        fb_colr_nx = wr ? colr_q : fb_colr;
    end
    // datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
            cnt <= '0;
            rate_q <= '0;
            colr_q <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            fb_we <= 1'b0;
            fb_addr <= '0;
            fb_colr <= '0;
        end else begin
            lfsr <= lfsr_nx;
            cnt <= cnt_nx;
            rate_q <= rate_nx;
            colr_q <= colr_nx;
            busy <= busy_nx;
            done <= done_nx;
            fb_we <= fb_we_nx;
            fb_addr <= fb_addr_nx;
            fb_colr <= fb_colr_nx;
        end
    end
endmodule

// File: tb/tb_fb_fizzle_writer.sv
// tb_fb_fizzle_writer: scoreboard bench for a 4-bit-LFSR instance and a full-size instance
module tb_fb_fizzle_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_start = 1'b0, s_stop = 1'b0;
    logic [3:0] s_colr = '0;
    logic [15:0] s_rate = '0;
    logic s_busy, s_done, s_we;
    logic [3:0] s_addr, s_colr_o;
    logic b_start = 1'b0, b_stop = 1'b0;
    logic [3:0] b_colr = '0;
    logic [15:0] b_rate = '0;
    logic b_busy, b_done, b_we;
    logic [14:0] b_addr;
    logic [3:0] b_colr_o;

    typedef struct packed {logic [3:0] addr; logic [3:0] colr;} wr_t;
    wr_t exp_q[$];
    wr_t e;
    int gap_q[$];
    int errors = 0, checks = 0;
    int cyc = 0, last_we = 0;
    int s_busy_tot = 0, s_done_tot = 0, s_we_tot = 0;
    int b_busy_tot = 0, b_done_tot = 0, b_we_tot = 0;
    bit seen [32768];
    int small_seq [12] = '{0, 11, 5, 2, 9, 4, 6, 10, 8, 7, 3, 1};
    int exp_gap [11] = '{3, 3, 3, 4, 3, 4, 4, 3, 3, 3, 3};

    always #5 clk = ~clk;

    fb_fizzle_writer #(
        .FB_PIXELS(12), .FB_ADDRW(4), .CIDXW(4), .LFSR_LEN(4),
        .TAPS(4'b1100), .SEED(4'd1), .RATEW(16)
    ) u_small (
        .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .colr(s_colr), .rate(s_rate),
        .busy(s_busy), .done(s_done), .fb_we(s_we), .fb_addr(s_addr), .fb_colr(s_colr_o)
    );

    fb_fizzle_writer u_big (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .colr(b_colr), .rate(b_rate),
        .busy(b_busy), .done(b_done), .fb_we(b_we), .fb_addr(b_addr), .fb_colr(b_colr_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every small-instance write, tracks the big instance coverage
    always @(negedge clk) begin
        cyc++;
        if (s_busy) s_busy_tot++;
        if (s_done) s_done_tot++;
        if (b_busy) b_busy_tot++;
        if (b_done) b_done_tot++;
        if (s_we) begin
            s_we_tot++;
            gap_q.push_back(cyc - last_we - 1);
            last_we = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_write: got addr %0d expected no write", s_addr);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", int'(s_addr), int'(e.addr));
                chk("write_colr", int'(s_colr_o), int'(e.colr));
            end
        end
        if (b_we) begin
            b_we_tot++;
            checks++;
            if (int'(b_addr) >= 19200 || seen[b_addr] || b_colr_o != 4'd3) begin
                errors++;
                $display("FAIL big_write: got addr %0d colr %0d seen %0d expected unseen addr below 19200 colr 3",
                         b_addr, b_colr_o, seen[b_addr]);
            end
            seen[b_addr] = 1'b1;
        end
    end

    task automatic push_seq(input int n, input logic [3:0] c);
        for (int i = 0; i < n; i++) exp_q.push_back(wr_t'{4'(small_seq[i]), c});
    endtask

    task automatic pulse_s(input logic [3:0] c, input logic [15:0] r);
        s_colr = c;
        s_rate = r;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
    endtask

    task automatic wait_s_idle(input int bound, input string nm);
        int n = 0;
        while (s_busy && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_idle_timeout"}, int'(s_busy), 0);
    endtask

    initial begin
        int sb, sd, sw, n, k;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_done", int'(s_done), 0);
        chk("rst_we", int'(s_we), 0);
        chk("rst_addr", int'(s_addr), 0);
        chk("rst_colr", int'(s_colr_o), 0);
        chk("rst_big_busy", int'(b_busy), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // full-size run, rate 0
        b_colr = 4'd3;
        b_rate = '0;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n = 0;
        while (b_busy && n < 40000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("big_idle_timeout", int'(b_busy), 0);
        @(negedge clk); #1;
        chk("big_writes", b_we_tot, 19200);
        chk("big_busy_cycles", b_busy_tot, 32768);
        chk("big_done", b_done_tot, 1);

        // exact sequence, rate 0
        push_seq(12, 4'd5);
        sb = s_busy_tot; sd = s_done_tot;
        pulse_s(4'd5, 16'd0);
        wait_s_idle(100, "seq");
        @(negedge clk); #1;
        chk("seq_busy_cycles", s_busy_tot - sb, 16);
        chk("seq_done", s_done_tot - sd, 1);
        chk("seq_pending", exp_q.size(), 0);

        // rate spacing, rate 3
        push_seq(12, 4'd5);
        gap_q.delete();
        sb = s_busy_tot;
        pulse_s(4'd5, 16'd3);
        wait_s_idle(200, "rate");
        @(negedge clk); #1;
        chk("rate_busy_cycles", s_busy_tot - sb, 52);
        chk("rate_gap_count", gap_q.size(), 12);
        if (gap_q.size() == 12) begin
            void'(gap_q.pop_front());
            for (int i = 0; i < 11; i++) chk($sformatf("rate_gap%0d", i), gap_q.pop_front(), exp_gap[i]);
        end
        chk("rate_pending", exp_q.size(), 0);

        // start held high, colour changed mid-run
        push_seq(12, 4'd5);
        sb = s_busy_tot; sd = s_done_tot;
        s_colr = 4'd5;
        s_rate = 16'd1;
        s_start = 1'b1;
        repeat (6) @(posedge clk);
        #1 s_colr = 4'd9;
        wait_s_idle(200, "hold");
        s_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done_once", s_done_tot - sd, 1);
        chk("hold_no_restart", int'(s_busy), 0);
        chk("hold_busy_cycles", s_busy_tot - sb, 28);
        chk("hold_pending", exp_q.size(), 0);

        // start together with stop is ignored
        sb = s_busy_tot;
        s_start = 1'b1;
        s_stop = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        s_stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("startstop_busy", int'(s_busy), 0);
        chk("startstop_busy_cycles", s_busy_tot - sb, 0);

        // abort after the 4th write, then restart
        push_seq(4, 4'd5);
        sd = s_done_tot; sw = s_we_tot;
        pulse_s(4'd5, 16'd0);
        n = 0; k = 0;
        while (n < 4 && k < 50) begin
            @(posedge clk); #1;
            k++;
            if (s_we) n++;
        end
        chk("abort_reach_4th", n, 4);
        s_stop = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_we", int'(s_we), 0);
        s_stop = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", s_done_tot - sd, 0);
        chk("abort_writes", s_we_tot - sw, 4);
        push_seq(12, 4'd5);
        sd = s_done_tot;
        pulse_s(4'd5, 16'd0);
        wait_s_idle(100, "restart");
        @(negedge clk); #1;
        chk("restart_done", s_done_tot - sd, 1);
        chk("restart_pending", exp_q.size(), 0);

        // async reset between clock edges while a write is on the port
        push_seq(12, 4'd5);
        pulse_s(4'd5, 16'd2);
        k = 0;
        while (!s_we && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("areset_we_before", int'(s_we), 1);
        chk("areset_busy_before", int'(s_busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("areset_busy", int'(s_busy), 0);
        chk("areset_we", int'(s_we), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", int'(s_busy), 0);
        chk("post_rst_we", int'(s_we), 0);
        chk("post_rst_addr", int'(s_addr), 0);
        chk("post_rst_colr", int'(s_colr_o), 0);
        chk("post_rst_done", int'(s_done), 0);
        push_seq(12, 4'd5);
        sd = s_done_tot;
        pulse_s(4'd5, 16'd0);
        wait_s_idle(100, "final");
        @(negedge clk); #1;
        chk("final_done", s_done_tot - sd, 1);
        chk("final_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
